// File: rtl/cv32e40p_rvfi_pkg.sv
// Shared types for the RVFI retirement tracker; the fp field exists only
// under CV32E40P_RVFI_TRACKER_FREG_EN.
package cv32e40p_rvfi_pkg;

  localparam int RVFI_ORDER_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd0_addr;
    logic [31:0] rd0_wdata;
`ifdef CV32E40P_RVFI_TRACKER_FREG_EN
    logic        fp;
`endif
    logic        pending;
    logic [4:0]  rd1_addr;
    logic        filled;
    logic [31:0] rd1_wdata;
  } rvfi_entry_t;

endpackage

// File: rtl/cv32e40p_rvfi_entry_fifo.sv
// In-order record store with a fill port that targets the oldest record still
// owed a writeback; head is offered once it is filled, fill lands one cycle later.
module cv32e40p_rvfi_entry_fifo
  import cv32e40p_rvfi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  rvfi_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        head_ready,
  output rvfi_entry_t head_data,
  input  logic        fill,
  input  logic [31:0] fill_data,
  output logic        fill_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  rvfi_entry_t mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] wb_ptr;
  logic [PW-1:0] count;

  logic [PW-1:0] wb_dist;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] scan_ptr;
  logic          scan_found;

  // wb_ptr is a lower bound: everything between head and wb_ptr is already
  // filled or never pending, so the search only walks forward from it.
  // Entries pushed this cycle sit at tail and are outside the search range.
  always_comb begin
    wb_dist    = tail - wb_ptr;
    scan_idx   = wb_ptr;
    scan_ptr   = tail;
    scan_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = wb_ptr + PW'(i);
      if (!scan_found && (PW'(i) < wb_dist) &&
          mem[scan_idx[AW-1:0]].pending && !mem[scan_idx[AW-1:0]].filled) begin
        scan_found = 1'b1;
        scan_ptr   = scan_idx;
      end
    end
  end

  assign fill_hit   = scan_found;
  assign full       = (count == PW'(DEPTH));
  assign head_data  = mem[head[AW-1:0]];
  assign head_ready = (count != '0) && head_data.filled;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      wb_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count  <= count + PW'(push) - PW'(pop);
      wb_ptr <= (fill && scan_found) ? scan_ptr + PW'(1) : scan_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail[AW-1:0]] <= push_data;
    if (fill && scan_found) begin
      mem[scan_ptr[AW-1:0]].filled    <= 1'b1;
      mem[scan_ptr[AW-1:0]].rd1_wdata <= fill_data;
    end
  end

endmodule

// File: rtl/cv32e40p_rvfi_retire_tracker.sv
// RVFI retirement producer: merges late writebacks into in-order records, one
// retire per cycle, issue-to-retire 1 cycle; FP lane-0 routing under CV32E40P_RVFI_TRACKER_FREG_EN.
module cv32e40p_rvfi_retire_tracker
  import cv32e40p_rvfi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FPU   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [31:0]             issue_pc_i,
  input  logic [31:0]             issue_insn_i,
  input  logic [4:0]              issue_rs1_addr_i,
  input  logic [4:0]              issue_rs2_addr_i,
  input  logic [31:0]             issue_rs1_rdata_i,
  input  logic [31:0]             issue_rs2_rdata_i,
  input  logic [4:0]              issue_rd0_addr_i,
  input  logic [31:0]             issue_rd0_wdata_i,
  input  logic                    issue_rd1_pending_i,
  input  logic [4:0]              issue_rd1_addr_i,
  input  logic                    issue_rd_fp_i,
  input  logic                    wb_valid_i,
  input  logic [31:0]             wb_wdata_i,
  output logic                    rvfi_valid,
  output logic [RVFI_ORDER_W-1:0] rvfi_order,
  output logic [31:0]             rvfi_insn,
  output logic [31:0]             rvfi_pc_rdata,
  output logic [4:0]              rvfi_rs1_addr,
  output logic [4:0]              rvfi_rs2_addr,
  output logic [31:0]             rvfi_rs1_rdata,
  output logic [31:0]             rvfi_rs2_rdata,
  output logic [1:0][4:0]         rvfi_rd_addr,
  output logic [1:0][31:0]        rvfi_rd_wdata,
  output logic [1:0]              rvfi_frd_wvalid,
  output logic [1:0][4:0]         rvfi_frd_addr,
  output logic [1:0][31:0]        rvfi_frd_wdata,
  output logic                    protocol_err_o
);

  rvfi_entry_t issue_entry;
  rvfi_entry_t head_entry;
  logic        push;
  logic        pop;
  logic        full;
  logic        head_ready;
  logic        fill_hit;

  logic [RVFI_ORDER_W-1:0] next_order;

  logic [1:0][4:0]  rd_addr_n;
  logic [1:0][31:0] rd_wdata_n;
  logic [1:0]       frd_wvalid_n;
  logic [1:0][4:0]  frd_addr_n;
  logic [1:0][31:0] frd_wdata_n;

  always_comb begin
    issue_entry           = '0;
    issue_entry.pc        = issue_pc_i;
    issue_entry.insn      = issue_insn_i;
    issue_entry.rs1_addr  = issue_rs1_addr_i;
    issue_entry.rs2_addr  = issue_rs2_addr_i;
    issue_entry.rs1_rdata = issue_rs1_rdata_i;
    issue_entry.rs2_rdata = issue_rs2_rdata_i;
    issue_entry.rd0_addr  = issue_rd0_addr_i;
    issue_entry.rd0_wdata = issue_rd0_wdata_i;
    issue_entry.pending   = issue_rd1_pending_i;
    issue_entry.rd1_addr  = issue_rd1_addr_i;
    issue_entry.filled    = !issue_rd1_pending_i;
`ifdef CV32E40P_RVFI_TRACKER_FREG_EN
    issue_entry.fp        = issue_rd_fp_i;
`endif
  end

  // Ready comes from the registered count only, so a retire never frees a
  // slot for an issue in the same cycle.
  assign issue_ready_o = !full;
  assign push          = issue_valid_i && !full;
  assign pop           = head_ready;

  cv32e40p_rvfi_entry_fifo #(
    .DEPTH(DEPTH)
  ) u_entry_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_data  (issue_entry),
    .pop        (pop),
    .full       (full),
    .head_ready (head_ready),
    .head_data  (head_entry),
    .fill       (wb_valid_i),
    .fill_data  (wb_wdata_i),
    .fill_hit   (fill_hit)
  );

  always_comb begin
    rd_addr_n     = '0;
    rd_wdata_n    = '0;
    frd_wvalid_n  = '0;
    frd_addr_n    = '0;
    frd_wdata_n   = '0;
    rd_addr_n[1]  = head_entry.pending ? head_entry.rd1_addr : 5'd0;
    rd_wdata_n[1] = head_entry.rd1_wdata;
`ifdef CV32E40P_RVFI_TRACKER_FREG_EN
    if (head_entry.fp) begin
      frd_wvalid_n[0] = 1'b1;
      frd_addr_n[0]   = head_entry.rd0_addr;
      frd_wdata_n[0]  = head_entry.rd0_wdata;
    end else begin
      rd_addr_n[0]    = head_entry.rd0_addr;
      rd_wdata_n[0]   = head_entry.rd0_wdata;
    end
`else
    rd_addr_n[0]  = head_entry.rd0_addr;
    rd_wdata_n[0] = head_entry.rd0_wdata;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvfi_valid      <= 1'b0;
      rvfi_order      <= '0;
      next_order      <= '0;
      rvfi_insn       <= '0;
      rvfi_pc_rdata   <= '0;
      rvfi_rs1_addr   <= '0;
      rvfi_rs2_addr   <= '0;
      rvfi_rs1_rdata  <= '0;
      rvfi_rs2_rdata  <= '0;
      rvfi_rd_addr    <= '0;
      rvfi_rd_wdata   <= '0;
      rvfi_frd_wvalid <= '0;
      rvfi_frd_addr   <= '0;
      rvfi_frd_wdata  <= '0;
      protocol_err_o  <= 1'b0;
    end else begin
      rvfi_valid <= pop;
      // A writeback with no owed record (including one issued this cycle) is dropped.
      if (wb_valid_i && !fill_hit) protocol_err_o <= 1'b1;
      if (pop) begin
        rvfi_order      <= next_order;
        next_order      <= next_order + RVFI_ORDER_W'(1);
        rvfi_insn       <= head_entry.insn;
        rvfi_pc_rdata   <= head_entry.pc;
        rvfi_rs1_addr   <= head_entry.rs1_addr;
        rvfi_rs2_addr   <= head_entry.rs2_addr;
        rvfi_rs1_rdata  <= head_entry.rs1_rdata;
        rvfi_rs2_rdata  <= head_entry.rs2_rdata;
        rvfi_rd_addr    <= rd_addr_n;
        rvfi_rd_wdata   <= rd_wdata_n;
        rvfi_frd_wvalid <= frd_wvalid_n;
        rvfi_frd_addr   <= frd_addr_n;
        rvfi_frd_wdata  <= frd_wdata_n;
      end
    end
  end

  logic unused_ok;
`ifdef CV32E40P_RVFI_TRACKER_FREG_EN
  assign unused_ok = ^{head_entry.filled, (FPU != 0)};
`else
  assign unused_ok = ^{head_entry.filled, issue_rd_fp_i, (FPU != 0)};
`endif

endmodule

// File: tb/tb_cv32e40p_rvfi_retire_tracker.sv
// Directed self-checking bench for the RVFI retirement tracker.
module tb_cv32e40p_rvfi_retire_tracker;

  logic              clk_i;
  logic              rst_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [31:0]       issue_pc_i;
  logic [31:0]       issue_insn_i;
  logic [4:0]        issue_rs1_addr_i;
  logic [4:0]        issue_rs2_addr_i;
  logic [31:0]       issue_rs1_rdata_i;
  logic [31:0]       issue_rs2_rdata_i;
  logic [4:0]        issue_rd0_addr_i;
  logic [31:0]       issue_rd0_wdata_i;
  logic              issue_rd1_pending_i;
  logic [4:0]        issue_rd1_addr_i;
  logic              issue_rd_fp_i;
  logic              wb_valid_i;
  logic [31:0]       wb_wdata_i;
  logic              rvfi_valid;
  logic [63:0]       rvfi_order;
  logic [31:0]       rvfi_insn;
  logic [31:0]       rvfi_pc_rdata;
  logic [4:0]        rvfi_rs1_addr;
  logic [4:0]        rvfi_rs2_addr;
  logic [31:0]       rvfi_rs1_rdata;
  logic [31:0]       rvfi_rs2_rdata;
  logic [1:0][4:0]   rvfi_rd_addr;
  logic [1:0][31:0]  rvfi_rd_wdata;
  logic [1:0]        rvfi_frd_wvalid;
  logic [1:0][4:0]   rvfi_frd_addr;
  logic [1:0][31:0]  rvfi_frd_wdata;
  logic              protocol_err_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_rvfi_retire_tracker #(.DEPTH(4), .FPU(0)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .issue_valid_i       (issue_valid_i),
    .issue_ready_o       (issue_ready_o),
    .issue_pc_i          (issue_pc_i),
    .issue_insn_i        (issue_insn_i),
    .issue_rs1_addr_i    (issue_rs1_addr_i),
    .issue_rs2_addr_i    (issue_rs2_addr_i),
    .issue_rs1_rdata_i   (issue_rs1_rdata_i),
    .issue_rs2_rdata_i   (issue_rs2_rdata_i),
    .issue_rd0_addr_i    (issue_rd0_addr_i),
    .issue_rd0_wdata_i   (issue_rd0_wdata_i),
    .issue_rd1_pending_i (issue_rd1_pending_i),
    .issue_rd1_addr_i    (issue_rd1_addr_i),
    .issue_rd_fp_i       (issue_rd_fp_i),
    .wb_valid_i          (wb_valid_i),
    .wb_wdata_i          (wb_wdata_i),
    .rvfi_valid          (rvfi_valid),
    .rvfi_order          (rvfi_order),
    .rvfi_insn           (rvfi_insn),
    .rvfi_pc_rdata       (rvfi_pc_rdata),
    .rvfi_rs1_addr       (rvfi_rs1_addr),
    .rvfi_rs2_addr       (rvfi_rs2_addr),
    .rvfi_rs1_rdata      (rvfi_rs1_rdata),
    .rvfi_rs2_rdata      (rvfi_rs2_rdata),
    .rvfi_rd_addr        (rvfi_rd_addr),
    .rvfi_rd_wdata       (rvfi_rd_wdata),
    .rvfi_frd_wvalid     (rvfi_frd_wvalid),
    .rvfi_frd_addr       (rvfi_frd_addr),
    .rvfi_frd_wdata      (rvfi_frd_wdata),
    .protocol_err_o      (protocol_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid_i       = 1'b0;
    issue_pc_i          = '0;
    issue_insn_i        = '0;
    issue_rs1_addr_i    = '0;
    issue_rs2_addr_i    = '0;
    issue_rs1_rdata_i   = '0;
    issue_rs2_rdata_i   = '0;
    issue_rd0_addr_i    = '0;
    issue_rd0_wdata_i   = '0;
    issue_rd1_pending_i = 1'b0;
    issue_rd1_addr_i    = '0;
    issue_rd_fp_i       = 1'b0;
    wb_valid_i          = 1'b0;
    wb_wdata_i          = '0;
  endtask

  task automatic drive_issue(input logic [31:0] pc, input logic [31:0] insn,
                             input logic [4:0] rd0a, input logic [31:0] rd0d,
                             input logic pend, input logic [4:0] rd1a, input logic fp);
    issue_valid_i       = 1'b1;
    issue_pc_i          = pc;
    issue_insn_i        = insn;
    issue_rs1_addr_i    = 5'd10;
    issue_rs2_addr_i    = 5'd11;
    issue_rs1_rdata_i   = 32'h0000_1000;
    issue_rs2_rdata_i   = 32'h0000_2000;
    issue_rd0_addr_i    = rd0a;
    issue_rd0_wdata_i   = rd0d;
    issue_rd1_pending_i = pend;
    issue_rd1_addr_i    = rd1a;
    issue_rd_fp_i       = fp;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h, expected 0", rvfi_valid); end
    checks++; if (rvfi_order !== 64'd0) begin errors++; $display("FAIL reset_order: got %h, expected 0", rvfi_order); end
    checks++; if (rvfi_pc_rdata !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h, expected 0", rvfi_pc_rdata); end
    checks++; if (rvfi_rd_wdata !== 64'd0) begin errors++; $display("FAIL reset_rd_wdata: got %h, expected 0", rvfi_rd_wdata); end
    checks++; if (rvfi_frd_wvalid !== 2'd0) begin errors++; $display("FAIL reset_frd_wvalid: got %h, expected 0", rvfi_frd_wvalid); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %h, expected 1", issue_ready_o); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %h, expected 0", protocol_err_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    drive_issue(32'h80, 32'h0050_0093, 5'd1, 32'd5, 1'b0, 5'd0, 1'b0);
    tick();
    clear_inputs();
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL alu_early_valid: got %h, expected 0", rvfi_valid); end
    tick();
    checks++; if (rvfi_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %h, expected 1", rvfi_valid); end
    checks++; if (rvfi_order !== 64'd0) begin errors++; $display("FAIL alu_order: got %h, expected 0", rvfi_order); end
    checks++; if (rvfi_pc_rdata !== 32'h80) begin errors++; $display("FAIL alu_pc: got %h, expected 80", rvfi_pc_rdata); end
    checks++; if (rvfi_insn !== 32'h0050_0093) begin errors++; $display("FAIL alu_insn: got %h, expected 00500093", rvfi_insn); end
    checks++; if (rvfi_rs1_addr !== 5'd10 || rvfi_rs1_rdata !== 32'h1000) begin errors++; $display("FAIL alu_rs1: got %h/%h, expected 0a/1000", rvfi_rs1_addr, rvfi_rs1_rdata); end
    checks++; if (rvfi_rd_addr[0] !== 5'd1) begin errors++; $display("FAIL alu_rd0_addr: got %h, expected 1", rvfi_rd_addr[0]); end
    checks++; if (rvfi_rd_wdata[0] !== 32'd5) begin errors++; $display("FAIL alu_rd0_wdata: got %h, expected 5", rvfi_rd_wdata[0]); end
    checks++; if (rvfi_rd_addr[1] !== 5'd0) begin errors++; $display("FAIL alu_rd1_addr: got %h, expected 0", rvfi_rd_addr[1]); end
    tick();
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse: got %h, expected 0", rvfi_valid); end
    checks++; if (rvfi_pc_rdata !== 32'h80) begin errors++; $display("FAIL alu_hold_pc: got %h, expected 80", rvfi_pc_rdata); end
  endtask

  task automatic test_load_alu();
    do_reset();
    drive_issue(32'h100, 32'h0005_2103, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0);
    tick();
    drive_issue(32'h104, 32'h0010_0193, 5'd3, 32'd1, 1'b0, 5'd0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL hol_block_a: got %h, expected 0", rvfi_valid); end
    tick();
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL hol_block_b: got %h, expected 0", rvfi_valid); end
    wb_valid_i = 1'b1;
    wb_wdata_i = 32'hDEAD_BEEF;
    tick();
    wb_valid_i = 1'b0;
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL load_wb_latency: got %h, expected 0", rvfi_valid); end
    tick();
    checks++; if (rvfi_valid !== 1'b1 || rvfi_pc_rdata !== 32'h100) begin errors++; $display("FAIL load_retire: got valid %h pc %h, expected 1/100", rvfi_valid, rvfi_pc_rdata); end
    checks++; if (rvfi_order !== 64'd0) begin errors++; $display("FAIL load_order: got %h, expected 0", rvfi_order); end
    checks++; if (rvfi_rd_addr[1] !== 5'd2 || rvfi_rd_wdata[1] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rd1: got %h/%h, expected 02/deadbeef", rvfi_rd_addr[1], rvfi_rd_wdata[1]); end
    tick();
    checks++; if (rvfi_valid !== 1'b1 || rvfi_pc_rdata !== 32'h104) begin errors++; $display("FAIL alu2_retire: got valid %h pc %h, expected 1/104", rvfi_valid, rvfi_pc_rdata); end
    checks++; if (rvfi_order !== 64'd1) begin errors++; $display("FAIL alu2_order: got %h, expected 1", rvfi_order); end
    checks++; if (rvfi_rd_addr[0] !== 5'd3 || rvfi_rd_addr[1] !== 5'd0) begin errors++; $display("FAIL alu2_rd: got %h/%h, expected 03/00", rvfi_rd_addr[0], rvfi_rd_addr[1]); end
    tick();
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL load_alu_idle: got %h, expected 0", rvfi_valid); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL load_alu_err: got %h, expected 0", protocol_err_o); end
  endtask

  task automatic test_full_back_to_back();
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_issue(32'h500 + 32'(4 * i), 32'h0000_2003, 5'd0, 32'd0, 1'b1, 5'(4 + i), 1'b0);
      tick();
    end
    clear_inputs();
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %h, expected 0", issue_ready_o); end
    wb_valid_i = 1'b1;
    wb_wdata_i = 32'h11;
    tick();
    wb_valid_i = 1'b0;
    checks++; if (issue_ready_o !== 1'b0 || rvfi_valid !== 1'b0) begin errors++; $display("FAIL full_after_wb: got ready %h valid %h, expected 0/0", issue_ready_o, rvfi_valid); end
    tick();
    checks++; if (rvfi_valid !== 1'b1 || rvfi_rd_addr[1] !== 5'd4 || rvfi_rd_wdata[1] !== 32'h11) begin errors++; $display("FAIL full_first_retire: got %h/%h/%h, expected 1/04/11", rvfi_valid, rvfi_rd_addr[1], rvfi_rd_wdata[1]); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_reopen: got %h, expected 1", issue_ready_o); end
    for (int k = 0; k < 4; k++) begin
      wb_valid_i = (k < 3);
      wb_wdata_i = 32'h22 + 32'(17 * k);
      tick();
      if (k == 0) begin
        checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %h, expected 0", rvfi_valid); end
      end else begin
        exp_d = 32'h22 + 32'(17 * (k - 1));
        checks++; if (rvfi_valid !== 1'b1 || rvfi_rd_wdata[1] !== exp_d || rvfi_order !== 64'(k)) begin errors++; $display("FAIL b2b_retire_%0d: got %h/%h/%0d, expected 1/%h/%0d", k, rvfi_valid, rvfi_rd_wdata[1], rvfi_order, exp_d, k); end
      end
    end
    wb_valid_i = 1'b0;
    tick();
    checks++; if (rvfi_valid !== 1'b0 || protocol_err_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid %h err %h, expected 0/0", rvfi_valid, protocol_err_o); end
  endtask

  task automatic test_spurious_wb();
    do_reset();
    wb_valid_i = 1'b1;
    wb_wdata_i = 32'h1234;
    tick();
    wb_valid_i = 1'b0;
    checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL spurious_err: got %h, expected 1", protocol_err_o); end
    checks++; if (rvfi_valid !== 1'b0) begin errors++; $display("FAIL spurious_valid: got %h, expected 0", rvfi_valid); end
    tick();
    tick();
    checks++; if (protocol_err_o !== 1'b1 || rvfi_valid !== 1'b0) begin errors++; $display("FAIL spurious_sticky: got err %h valid %h, expected 1/0", protocol_err_o, rvfi_valid); end
    do_reset();
    drive_issue(32'h600, 32'h0000_2183, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
    wb_valid_i = 1'b1;
    wb_wdata_i = 32'hBAD0_BAD0;
    tick();
    clear_inputs();
    checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL same_cycle_err: got %h, expected 1", protocol_err_o); end
    wb_valid_i = 1'b1;
    wb_wdata_i = 32'hCAFE;
    tick();
    wb_valid_i = 1'b0;
    tick();
    checks++; if (rvfi_valid !== 1'b1 || rvfi_rd_addr[1] !== 5'd9 || rvfi_rd_wdata[1] !== 32'hCAFE) begin errors++; $display("FAIL same_cycle_owed: got %h/%h/%h, expected 1/09/cafe", rvfi_valid, rvfi_rd_addr[1], rvfi_rd_wdata[1]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_issue(32'h200, 32'h0010_0213, 5'd4, 32'd1, 1'b0, 5'd0, 1'b0);
    tick();
    drive_issue(32'h204, 32'h0020_0293, 5'd5, 32'd2, 1'b0, 5'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_issue(32'h208 + 32'(4 * i), 32'h0000_2303, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0);
      tick();
    end
    clear_inputs();
    checks++; if (rvfi_order !== 64'd1 || rvfi_pc_rdata !== 32'h204) begin errors++; $display("FAIL pre_reset: got order %0d pc %h, expected 1/204", rvfi_order, rvfi_pc_rdata); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (rvfi_valid !== 1'b0 || rvfi_order !== 64'd0 || rvfi_pc_rdata !== 32'd0 || rvfi_rd_wdata !== 64'd0) begin errors++; $display("FAIL async_reset: got %h/%0d/%h/%h, expected all 0", rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_rd_wdata); end
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %h, expected 1", issue_ready_o); end
    tick();
    rst_i = 1'b0;
    drive_issue(32'h300, 32'h0070_0293, 5'd5, 32'd7, 1'b0, 5'd0, 1'b0);
    tick();
    clear_inputs();
    tick();
    checks++; if (rvfi_valid !== 1'b1 || rvfi_order !== 64'd0 || rvfi_pc_rdata !== 32'h300) begin errors++; $display("FAIL post_reset_retire: got %h/%0d/%h, expected 1/0/300", rvfi_valid, rvfi_order, rvfi_pc_rdata); end
    wb_valid_i = 1'b1;
    tick();
    wb_valid_i = 1'b0;
    checks++; if (protocol_err_o !== 1'b1 || rvfi_valid !== 1'b0) begin errors++; $display("FAIL discarded_entries: got err %h valid %h, expected 1/0", protocol_err_o, rvfi_valid); end
  endtask

  task automatic test_fp();
    do_reset();
    drive_issue(32'h400, 32'hF000_01D3, 5'd3, 32'h3F80_0000, 1'b0, 5'd0, 1'b1);
    tick();
    clear_inputs();
    tick();
    checks++; if (rvfi_valid !== 1'b1) begin errors++; $display("FAIL fp_valid: got %h, expected 1", rvfi_valid); end
`ifdef CV32E40P_RVFI_TRACKER_FREG_EN
    checks++; if (rvfi_frd_wvalid !== 2'b01 || rvfi_frd_addr[0] !== 5'd3 || rvfi_frd_wdata[0] !== 32'h3F80_0000) begin errors++; $display("FAIL fp_lane0: got %h/%h/%h, expected 01/03/3f800000", rvfi_frd_wvalid, rvfi_frd_addr[0], rvfi_frd_wdata[0]); end
    checks++; if (rvfi_rd_addr[0] !== 5'd0) begin errors++; $display("FAIL fp_int_rd0: got %h, expected 0", rvfi_rd_addr[0]); end
`else
    checks++; if (rvfi_frd_wvalid !== 2'b00 || rvfi_frd_addr !== 10'd0 || rvfi_frd_wdata !== 64'd0) begin errors++; $display("FAIL fp_tied: got %h/%h/%h, expected 0/0/0", rvfi_frd_wvalid, rvfi_frd_addr, rvfi_frd_wdata); end
    checks++; if (rvfi_rd_addr[0] !== 5'd3 || rvfi_rd_wdata[0] !== 32'h3F80_0000) begin errors++; $display("FAIL fp_ignored: got %h/%h, expected 03/3f800000", rvfi_rd_addr[0], rvfi_rd_wdata[0]); end
`endif
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    test_reset();
    test_single_alu();
    test_load_alu();
    test_full_back_to_back();
    test_spurious_wb();
    test_reset_mid();
    test_fp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rvfi_retire_tracker.md
# cv32e40p_rvfi_retire_tracker

Producer side of the core's RVFI retirement stream: accepts one instruction record per cycle from the ID/EX boundary and merges in late register writebacks (LSU load results). It emits fully populated, in-order `rvfi_*` retirement records, one per cycle, for the trace and formal consumers. It is bind-level verification infrastructure and has no effect on core behaviour.

## Interface
Parameters:
- `DEPTH`, default 4: in-flight record capacity; power of two, at least 2.
- `FPU`, default 0: accepted for parameter-list symmetry with other RVFI blocks; has no functional effect (FP routing is controlled by the macro below).

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `issue_valid_i` input 1: record offered.
- `issue_ready_o` output 1: record accepted when valid && ready.
- `issue_pc_i` / `issue_insn_i` input 32 each: PC and raw instruction (compressed or not).
- `issue_rs1_addr_i` / `issue_rs2_addr_i` input 5 each, `issue_rs1_rdata_i` / `issue_rs2_rdata_i` input 32 each: source operands.
- `issue_rd0_addr_i` input 5, `issue_rd0_wdata_i` input 32: result known at issue (ALU, post-increment base). Addr 0 means no write.
- `issue_rd1_pending_i` input 1, `issue_rd1_addr_i` input 5: a late writeback is still owed to the record.
- `issue_rd_fp_i` input 1: rd0 targets the FP register file (macro only).
- `wb_valid_i` input 1, `wb_wdata_i` input 32: late writeback, strictly in issue order.
- `rvfi_valid` output 1, `rvfi_order` output 64, `rvfi_insn` / `rvfi_pc_rdata` output 32.
- `rvfi_rs1_addr` / `rvfi_rs2_addr` output 5, `rvfi_rs1_rdata` / `rvfi_rs2_rdata` output 32.
- `rvfi_rd_addr` output 5x[1:0], `rvfi_rd_wdata` output 32x[1:0]: lane 0 is the issue result, lane 1 is the late writeback.
- `rvfi_frd_wvalid` output 1x[1:0], `rvfi_frd_addr` output 5x[1:0], `rvfi_frd_wdata` output 32x[1:0].
- `protocol_err_o` output 1: sticky error flag.

## Operation
- Circular buffer of `DEPTH` entries with head pointer, tail pointer, writeback pointer and count, each `$clog2(DEPTH)+1` bits.
- Each entry holds the issue fields, `pending` and `filled` flags, and `rd1_wdata`.
- `issue_ready_o = (count != DEPTH)`. It is driven from registered state only; a retire in the same cycle does not free a slot for that cycle's issue.
- On issue: write the entry at tail and advance tail. `filled` = !pending.
- Writeback handling:
  - `wb_valid_i` fills the oldest entry with pending && !filled (the writeback pointer), then advances the pointer past non-pending entries.
  - If no such entry exists, the writeback is dropped and `protocol_err_o` is set.
  - A writeback targeting the entry issued in the same cycle is a protocol error: it is dropped and the flag is set.
- Retire: when count != 0 and the head entry is filled, register that entry onto the rvfi outputs, pulse `rvfi_valid`, advance head and decrement count.
  - Lane 1 addr is 0 when the entry was not pending.
- `rvfi_order` is the order of the presented record: the first record is 0, then +1 per retirement. It wraps modulo 2^64.
- Simultaneous issue + writeback + retire in one cycle is legal; count changes by (issue − retire).

## Timing
- Reset values: `rvfi_valid` 0; `rvfi_order` 0; all rvfi data outputs 0; `protocol_err_o` 0; buffer empty, so `issue_ready_o` = 1.
- Latency, non-pending record into an empty buffer: issue at cycle N → `rvfi_valid` at N+1.
- Latency, pending record: writeback at cycle M → retire at M+1 at the earliest.
- Head-of-line blocking: younger filled entries wait behind an unfilled head.
- Throughput: 1 retire per cycle.
- `rvfi_valid` is a single-cycle pulse per record. Data outputs hold their last value when `rvfi_valid` is low.
- Reset asserted mid-operation: all entries are discarded immediately. No partial record is emitted, and the order restarts at 0.

## Configuration
- `CV32E40P_RVFI_TRACKER_FREG_EN` defined:
  - Entries store `issue_rd_fp_i`.
  - Lane-0 FP records drive `rvfi_frd_wvalid[0]=1`, `rvfi_frd_addr[0]`, `rvfi_frd_wdata[0]`, and `rvfi_rd_addr[0]=0`.
  - Lane 1 is always an integer register.
- Macro undefined:
  - `issue_rd_fp_i` is ignored.
  - All `rvfi_frd_*` outputs are tied to 0.

## Structure
- Package `cv32e40p_rvfi_pkg` holds:
  - typedef `rvfi_entry_t`, a packed struct of the issue fields plus `pending`, `filled`, `rd1_wdata`, and `fp` under the macro;
  - constant `RVFI_ORDER_W = 64`.
- One sub-module, `cv32e40p_rvfi_entry_fifo`: storage, pointers and count, with a random-access fill port for the writeback pointer. Merge and order logic stay in the top module.

## Test plan
- Single ALU op: issue PC 0x80, insn 0x00500093, rd0 x1=5 → `rvfi_valid` at N+1, order 0, rd_addr[0]=1, rd_wdata[0]=5, rd_addr[1]=0.
- Load followed by ALU op: the load (pending, rd1 x2) issues, the ALU op issues next, writeback 0xDEADBEEF arrives 3 cycles later → load retires with rd_wdata[1]=0xDEADBEEF, ALU op retires the next cycle, orders 0 and 1.
- Full buffer: 4 pending issues with no writeback → `issue_ready_o`=0. A writeback and a retire in the same cycle leave ready low that cycle; ready is high the cycle after.
- Spurious writeback on an empty buffer → no `rvfi_valid`, and `protocol_err_o` stays 1 until reset.
- Reset asserted with 3 entries queued → outputs 0 at once. Post-reset first retire has order 0.
- Macro defined, FP rd0 f3=0x3F800000 → frd_wvalid[0]=1, frd_addr[0]=3, rd_addr[0]=0. Macro undefined → frd_* = 0.
